// File: rtl/ps2_key_reader.sv
// ---------------------------------------------------------------------------
// ps2_key_reader
//
// Receives PS/2 keyboard frames and queues each good byte in a small FIFO.
// A memory-mapped read port returns either the FIFO head (which is popped)
// or a status word.
//
// A PS/2 frame has 11 bits, each sampled on a falling edge of PS2_CLK:
// a start bit (0), eight data bits (LSB first), an odd-parity bit and a
// stop bit (1).
//
// Parameters
//   TIMEOUT_CYC  maximum CLK_50MHZ cycles allowed between PS/2 clock falling
//                edges inside a frame before the frame is abandoned
//   DEPTH        receive FIFO depth in bytes (power of two, 2..16)
//
// Ports
//   CLK_50MHZ   in   system clock, the only clock in the block
//   reset       in   synchronous active-high reset
//   PS2_CLK     in   keyboard clock pin (asynchronous)
//   PS2_DATA    in   keyboard data pin (asynchronous)
//   rd_en       in   read strobe, one cycle per access
//   rd_sel      in   0 = data register (pop), 1 = status register
//   rd_data     out  registered read result
//                    status = {byte_avail, overflow, frame_err, 8'b0, count}
//   byte_avail  out  high while the FIFO holds at least one byte
// ---------------------------------------------------------------------------
module ps2_key_reader #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int DEPTH       = 8
) (
  input  logic        CLK_50MHZ,
  input  logic        reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [15:0] rd_data,
  output logic        byte_avail
);

  localparam int AW = $clog2(DEPTH);

  // -------------------------------------------------------------------------
  // Pin synchronizers: bit 0 = PS2_CLK, bit 1 = PS2_DATA.
  // Both flops of each stage come out of reset high, matching the idle bus.
  // -------------------------------------------------------------------------
  logic [1:0] pinRaw;
  logic [1:0] pinSync;

  assign pinRaw = {PS2_DATA, PS2_CLK};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gSync
      logic [1:0] stageReg;

      always_ff @(posedge CLK_50MHZ) begin
        if (reset) begin
          stageReg <= 2'b11;
        end else begin
          stageReg <= {stageReg[0], pinRaw[gi]};
        end
      end

      assign pinSync[gi] = stageReg[1];
    end
  endgenerate

  logic ps2ClkSync;
  logic ps2DataSync;
  logic ps2ClkPrevReg;
  logic fallEdge;

  assign ps2ClkSync  = pinSync[0];
  assign ps2DataSync = pinSync[1];
  assign fallEdge    = ps2ClkPrevReg & ~ps2ClkSync;

  always_ff @(posedge CLK_50MHZ) begin
    if (reset) begin
      ps2ClkPrevReg <= 1'b1;
    end else begin
      ps2ClkPrevReg <= ps2ClkSync;
    end
  end

  // -------------------------------------------------------------------------
  // Receiver FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rxState_t;

  rxState_t    stateReg,    stateNext;
  logic [2:0]  bitCntReg,   bitCntNext;
  logic [7:0]  shiftReg,    shiftNext;
  logic        parityReg,   parityNext;
  logic [15:0] timeoutReg,  timeoutNext;
  logic        pushReg,     pushNext;
  logic        frameErrSet;

  always_ff @(posedge CLK_50MHZ) begin
    if (reset) begin
      stateReg   <= IDLE;
      bitCntReg  <= 3'd0;
      shiftReg   <= 8'h00;
      parityReg  <= 1'b0;
      timeoutReg <= 16'd0;
      pushReg    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      bitCntReg  <= bitCntNext;
      shiftReg   <= shiftNext;
      parityReg  <= parityNext;
      timeoutReg <= timeoutNext;
      pushReg    <= pushNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    bitCntNext  = bitCntReg;
    shiftNext   = shiftReg;
    parityNext  = parityReg;
    timeoutNext = 16'd0;
    pushNext    = 1'b0;
    frameErrSet = 1'b0;

    // Inter-edge watchdog only runs while a frame is in progress.
    if (stateReg != IDLE) begin
      timeoutNext = fallEdge ? 16'd0 : timeoutReg + 16'd1;
    end

    if (stateReg != IDLE && timeoutReg == 16'(TIMEOUT_CYC)) begin
      // Keyboard went quiet mid-frame: drop the partial byte.
      stateNext   = IDLE;
      timeoutNext = 16'd0;
      frameErrSet = 1'b1;
    end else if (fallEdge) begin
      unique case (stateReg)
        IDLE: begin
          if (!ps2DataSync) begin
            stateNext  = DATA;
            bitCntNext = 3'd0;
          end
        end
        DATA: begin
          shiftNext  = {ps2DataSync, shiftReg[7:1]};
          bitCntNext = bitCntReg + 3'd1;
          if (bitCntReg == 3'd7) begin
            stateNext = PARITY;
          end
        end
        PARITY: begin
          parityNext = ps2DataSync;
          stateNext  = STOP;
        end
        STOP: begin
          if (ps2DataSync && (^{shiftReg, parityReg})) begin
            pushNext = 1'b1;
          end else begin
            frameErrSet = 1'b1;
          end
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Receive FIFO and read port.
  // shiftReg is stable while pushReg is high: it only shifts in DATA, and
  // the FSM cannot leave IDLE within one cycle of the stop-bit edge.
  // -------------------------------------------------------------------------
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wrPtrReg;
  logic [AW-1:0] rdPtrReg;
  logic [AW:0]   countReg;
  logic          overflowReg;
  logic          frameErrReg;

  logic fifoFull;
  logic fifoEmpty;
  logic popDo;
  logic pushDo;
  logic statusRead;
  logic [15:0] statusWord;

  assign fifoFull   = (countReg == (AW + 1)'(DEPTH));
  assign fifoEmpty  = (countReg == '0);
  assign byte_avail = ~fifoEmpty;
  assign statusRead = rd_en & rd_sel;
  // A pop on an empty FIFO is simply ignored, even if a push lands the
  // same cycle.
  assign popDo      = rd_en & ~rd_sel & ~fifoEmpty;
  // When full, a push survives only if a pop frees a slot in the same cycle.
  assign pushDo     = pushReg & (~fifoFull | popDo);
  assign statusWord = {byte_avail, overflowReg, frameErrReg, 8'h00, 5'(countReg)};

  always_ff @(posedge CLK_50MHZ) begin
    if (pushDo) begin
      mem[wrPtrReg] <= shiftReg;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (reset) begin
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      countReg    <= '0;
      overflowReg <= 1'b0;
      frameErrReg <= 1'b0;
      rd_data     <= 16'h0000;
    end else begin
      if (pushDo) begin
        wrPtrReg <= wrPtrReg + AW'(1);
      end
      if (popDo) begin
        rdPtrReg <= rdPtrReg + AW'(1);
      end

      unique case ({pushDo, popDo})
        2'b10:   countReg <= countReg + (AW + 1)'(1);
        2'b01:   countReg <= countReg - (AW + 1)'(1);
        default: countReg <= countReg;
      endcase

      // Sticky flags: a set in the same cycle as a status read wins.
      overflowReg <= (overflowReg & ~statusRead) | (pushReg & fifoFull & ~popDo);
      frameErrReg <= (frameErrReg & ~statusRead) | frameErrSet;

      if (rd_en) begin
        if (rd_sel) begin
          rd_data <= statusWord;
        end else if (popDo) begin
          rd_data <= {8'h00, mem[rdPtrReg]};
        end else begin
          rd_data <= 16'h0000;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_reader.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_reader
//
// Directed bench for ps2_key_reader. The PS/2 bit clock and the watchdog
// limit are scaled down (80 system cycles per PS/2 bit, 300-cycle timeout)
// so the whole sequence stays short; the relationships between them match
// the real-rate case (bit period well inside the timeout).
// ---------------------------------------------------------------------------
module tb_ps2_key_reader;

  localparam int TO_CYC = 300;
  localparam int DEPTH  = 8;
  localparam int HALF   = 40;   // system cycles per PS/2 clock half-period

  logic        clk;
  logic        reset;
  logic        ps2Clk;
  logic        ps2Data;
  logic        rdEn;
  logic        rdSel;
  logic [15:0] rdData;
  logic        byteAvail;

  int testCnt = 0;
  int failCnt = 0;

  ps2_key_reader #(
    .TIMEOUT_CYC(TO_CYC),
    .DEPTH(DEPTH)
  ) dut (
    .CLK_50MHZ (clk),
    .reset     (reset),
    .PS2_CLK   (ps2Clk),
    .PS2_DATA  (ps2Data),
    .rd_en     (rdEn),
    .rd_sel    (rdSel),
    .rd_data   (rdData),
    .byte_avail(byteAvail)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic regRead(input logic sel, output logic [15:0] val);
    @(negedge clk);
    rdEn  = 1'b1;
    rdSel = sel;
    @(negedge clk);
    rdEn  = 1'b0;
    rdSel = 1'b0;
    val   = rdData;
  endtask

  // One PS/2 bit: data set while the clock is high, then a low pulse.
  task automatic ps2Bit(input logic b);
    ps2Data = b;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  // Full frame. With coPop set, a data read is issued so that it lands on
  // the same system clock as the push: the falling edge needs two cycles
  // through the synchronizer, one for the FSM, and the push happens on the
  // following edge.
  task automatic sendFrame(input logic [7:0] d, input logic par, input logic stp,
                           input logic coPop, output logic [15:0] popVal);
    popVal = 16'hxxxx;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(d[i]);
    ps2Bit(par);
    if (coPop) begin
      ps2Data = stp;
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (3) @(negedge clk);
      rdEn  = 1'b1;
      rdSel = 1'b0;
      @(negedge clk);
      rdEn   = 1'b0;
      popVal = rdData;
      repeat (HALF - 4) @(negedge clk);
      ps2Clk = 1'b1;
    end else begin
      ps2Bit(stp);
    end
    ps2Data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic goodFrame(input logic [7:0] d);
    logic [15:0] unused;
    sendFrame(d, ~^d, 1'b1, 1'b0, unused);
  endtask

  initial begin
    logic [15:0] v;

    reset   = 1'b1;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    rdEn    = 1'b0;
    rdSel   = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rd_data", rdData, 16'h0000);
    check("reset_byte_avail", {15'b0, byteAvail}, 16'h0000);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Basic good frame 0x1C
    goodFrame(8'h1C);
    check("1c_byte_avail", {15'b0, byteAvail}, 16'h0001);
    regRead(1'b1, v);  check("1c_status", v, 16'h8001);
    regRead(1'b0, v);  check("1c_data", v, 16'h001C);
    repeat (5) @(negedge clk);
    check("1c_hold", rdData, 16'h001C);
    regRead(1'b1, v);  check("1c_status_after", v, 16'h0000);

    // Bad parity
    sendFrame(8'hF0, 1'b0, 1'b1, 1'b0, v);
    check("parity_byte_avail", {15'b0, byteAvail}, 16'h0000);
    regRead(1'b1, v);  check("parity_status", v, 16'h2000);
    regRead(1'b1, v);  check("parity_status_clear", v, 16'h0000);

    // Bad stop bit with otherwise good parity
    sendFrame(8'h44, ~^8'h44, 1'b0, 1'b0, v);
    regRead(1'b1, v);  check("stop_status", v, 16'h2000);

    // Overflow: nine frames into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) goodFrame(8'(i));
    regRead(1'b1, v);  check("ovf_status", v, 16'hC008);
    for (int i = 1; i <= 8; i++) begin
      regRead(1'b0, v);
      check($sformatf("ovf_data%0d", i), v, 16'(i));
    end
    regRead(1'b0, v);  check("ovf_empty_read", v, 16'h0000);
    regRead(1'b1, v);  check("ovf_status_after", v, 16'h0000);

    // Watchdog: start + 3 data bits then silence
    ps2Bit(1'b0); ps2Bit(1'b1); ps2Bit(1'b0); ps2Bit(1'b1);
    ps2Data = 1'b1;
    repeat (150) @(negedge clk);
    regRead(1'b1, v);  check("to_before_limit", v, 16'h0000);
    repeat (200) @(negedge clk);
    regRead(1'b1, v);  check("to_status", v, 16'h2000);
    goodFrame(8'h5A);
    regRead(1'b1, v);  check("to_next_status", v, 16'h8001);
    regRead(1'b0, v);  check("to_next_data", v, 16'h005A);

    // Full FIFO with a pop coincident with the push
    for (int i = 0; i < 8; i++) goodFrame(8'h11 + 8'(i));
    regRead(1'b1, v);  check("full_status", v, 16'h8008);
    sendFrame(8'h19, ~^8'h19, 1'b1, 1'b1, v);
    check("copop_data", v, 16'h0011);
    regRead(1'b1, v);  check("copop_status", v, 16'h8008);
    for (int i = 0; i < 8; i++) begin
      regRead(1'b0, v);
      check($sformatf("copop_drain%0d", i), v, 16'h0012 + 16'(i));
    end
    regRead(1'b1, v);  check("copop_status_empty", v, 16'h0000);

    // Reset mid-frame, with a byte already queued
    goodFrame(8'h33);
    check("rst_pre_avail", {15'b0, byteAvail}, 16'h0001);
    ps2Bit(1'b0); ps2Bit(1'b1); ps2Bit(1'b1); ps2Bit(1'b0); ps2Bit(1'b1);
    ps2Data = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_byte_avail", {15'b0, byteAvail}, 16'h0000);
    regRead(1'b1, v);  check("rst_status", v, 16'h0000);
    goodFrame(8'h29);
    regRead(1'b1, v);  check("rst_next_status", v, 16'h8001);
    regRead(1'b0, v);  check("rst_next_data", v, 16'h0029);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/ps2_key_reader.md
PS2_KEY_READER -- requirements
Module: ps2_key_reader

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: maximum CLK_50MHZ cycles between PS/2 clock falling edges inside a frame (1 ms).
REQ-002 Parameter DEPTH, default 8: receive FIFO depth in bytes; power of two, 2..16.
REQ-003 CLK_50MHZ  input  1  system clock; the only clock in the block.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of CLK_50MHZ.
REQ-005 PS2_CLK  input  1  keyboard clock pin; asynchronous to CLK_50MHZ.
REQ-006 PS2_DATA  input  1  keyboard data pin; asynchronous to CLK_50MHZ.
REQ-007 rd_en  input  1  read strobe from memory controller, one cycle per access.
REQ-008 rd_sel  input  1  0 = data register (pop), 1 = status register.
REQ-009 rd_data  output  16  registered read result.
REQ-010 byte_avail  output  1  high while FIFO is non-empty.

Function
REQ-011 The block SHALL pass PS2_CLK and PS2_DATA each through a 2-flop synchronizer, and SHALL detect a falling edge when the synchronized clock is 0 and its previous sample was 1.
REQ-012 The receiver SHALL sample synchronized PS2_DATA only on detected falling edges.
REQ-013 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on an edge with data 0 (start bit), go to DATA with bit count 0; on an edge with data 1, stay in IDLE.
REQ-015 DATA: shift in 8 bits LSB first; after the 8th edge go to PARITY.
REQ-016 PARITY: capture the bit, go to STOP.
REQ-017 STOP: on the edge, if stop = 1 and the 9 bits (data + parity) have odd parity, push the byte; otherwise set sticky frame_err and discard; always return to IDLE.
REQ-018 The push SHALL occur on the clock after the stop-bit edge is detected.
REQ-019 In any state other than IDLE, a 16-bit counter SHALL clear on each edge and increment otherwise.
REQ-020 When the counter reaches TIMEOUT_CYC, the FSM SHALL return to IDLE, discard the partial byte and set frame_err.
REQ-021 The FIFO SHALL be circular, with read/write pointers wrapping at DEPTH and a count of 0..DEPTH.
REQ-022 A push when full with no same-cycle pop SHALL drop the byte and set sticky overflow.
REQ-023 A push and a pop in the same cycle when full SHALL both take effect, leaving count at DEPTH with no overflow.
REQ-024 A push and a pop in the same cycle when empty SHALL perform only the push; the pop is ignored.
REQ-025 On rd_en with rd_sel = 0: if non-empty, rd_data = {8'h00, head byte} on the next edge and the FIFO pops; if empty, rd_data = 16'h0000 and nothing changes.
REQ-026 On rd_en with rd_sel = 1: rd_data = {byte_avail, overflow, frame_err, 8'b0, count[4:0]} on the next edge, sampled before any same-cycle push, then overflow and frame_err clear.
REQ-027 A sticky flag set in the same cycle as a status read SHALL remain set.
REQ-028 rd_data SHALL hold its value when rd_en = 0.
REQ-029 byte_avail SHALL be derived combinationally from count != 0.

Reset
REQ-030 While reset = 1: FSM = IDLE; bit count, timeout counter, FIFO pointers and count = 0; overflow = frame_err = 0; rd_data = 16'h0000; byte_avail = 0; synchronizer flops = 1.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no push and no flag set.
REQ-032 FIFO contents need not be cleared.

Verification
REQ-033 Frame 0x1C (parity 0, stop 1) at a 12.5 kHz PS/2 clock -> byte_avail = 1; status read = 16'h8001; data read = 16'h001C; status read = 16'h0000.
REQ-034 Frame 0xF0 with parity 0 (bad) -> no push; status read = 16'h2000; second status read = 16'h0000.
REQ-035 Nine valid frames 0x01..0x09 with no reads -> status read = 16'hC008; eight data reads return 0x0001..0x0008; a ninth data read returns 16'h0000.
REQ-036 Start bit plus 3 data bits, then PS2_CLK held high for 50000 cycles -> FSM in IDLE; status read = 16'h2000; a following valid frame 0x5A is received correctly.
REQ-037 FIFO full, data read coincident with the push cycle of a new byte -> count stays 8, overflow = 0, FIFO order preserved.
REQ-038 reset pulsed after the 4th data bit -> byte_avail = 0, status = 16'h0000; the next valid frame 0x29 is received correctly.
